idct_v2: RTL

Inverse 2-D 8x8 DCT, the decoding counterpart of `dct_v2`. It accepts one block of 64 signed 32-bit coefficients, serially in row-major order, as `dct_v2` produces them. It reconstructs the 64 8-bit pixels through a row pass and a column pass over a single multiply-accumulate datapath. It streams the pixels out row-major and pulses `finish` after the last one.

---
 rtl/idct_pkg.sv | 30 +++
 rtl/idct_mac.sv | 33 +++
 rtl/idct_v2.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/idct_pkg.sv
// Shared definitions for the 8x8 inverse DCT: widths, FSM encoding and the
// Q12 cosine ROM, stored as C[k][n] at index k*8+n.
package idct_pkg;

  localparam int COEF_W = 32;
  localparam int PIX_W  = 8;
  localparam int FRAC   = 12;
  localparam int ACC_W  = 48;
  localparam int ROM_W  = 14;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ROW  = 3'd2,
    COL  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic signed [ROM_W-1:0] COS_ROM [64] = '{
    14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,
    14'sd2009,  14'sd1703,  14'sd1138,  14'sd400,  -14'sd400,  -14'sd1138, -14'sd1703, -14'sd2009,
    14'sd1892,  14'sd784,  -14'sd784,  -14'sd1892, -14'sd1892, -14'sd784,   14'sd784,   14'sd1892,
    14'sd1703, -14'sd400,  -14'sd2009, -14'sd1138,  14'sd1138,  14'sd2009,  14'sd400,  -14'sd1703,
    14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448,  14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448,
    14'sd1138, -14'sd2009,  14'sd400,   14'sd1703, -14'sd1703, -14'sd400,   14'sd2009, -14'sd1138,
    14'sd784,  -14'sd1892,  14'sd1892, -14'sd784,  -14'sd784,   14'sd1892, -14'sd1892,  14'sd784,
    14'sd400,  -14'sd1138,  14'sd1703, -14'sd2009,  14'sd2009, -14'sd1703,  14'sd1138, -14'sd400
  };

endpackage

// File: rtl/idct_mac.sv
// Signed multiply-accumulate shared by the row and column passes. The result
// already includes the current product, so it is final in the last tap cycle.
module idct_mac
  import idct_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic signed [COEF_W-1:0] a_i,
  input  logic signed [ROM_W-1:0]  b_i,
  output logic signed [ACC_W-1:0]  result_o
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC - 1));

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] prod;

  assign prod     = ACC_W'(a_i) * ACC_W'(b_i);
  assign acc_d    = (clear_i ? '0 : acc_q) + prod;
  assign result_o = (acc_d + HALF) >>> FRAC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/idct_v2.sv
// Inverse 8x8 DCT: loads 64 coefficients, runs a row pass into tmp RAM, then
// a column pass that streams clipped pixels out row-major.
module idct_v2
  import idct_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     coef_valid,
  input  logic signed [COEF_W-1:0] data_in,
  output logic [PIX_W-1:0]         data_out,
  output logic                     out_valid,
  output logic                     finish,
  output logic                     busy
);

  localparam logic signed [COEF_W-1:0] SAT_MAX = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [COEF_W-1:0] SAT_MIN = {1'b1, {(COEF_W-1){1'b0}}};

  state_e                  state_q;
  logic [5:0]              cnt_q;
  logic [3:0]              tap_q;
  logic signed [COEF_W-1:0] res_q;

  logic signed [COEF_W-1:0] coef_ram [64];
  logic signed [COEF_W-1:0] tmp_ram  [64];

  logic                    mac_clear;
  logic                    mac_en;
  logic signed [COEF_W-1:0] mac_a;
  logic signed [ROM_W-1:0]  mac_b;
  logic signed [ACC_W-1:0]  mac_res;
  logic signed [COEF_W-1:0] row_sat;
  logic [PIX_W-1:0]         col_clip;

  assign busy      = (state_q != IDLE);
  assign mac_clear = (tap_q == 4'd0);
  assign mac_en    = ((state_q == ROW) || (state_q == COL)) && (tap_q != 4'd8);

  // cnt_q is the element index (row, col); tap_q walks the 8-term dot product.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    if (state_q == ROW) begin
      mac_a = coef_ram[{cnt_q[5:3], tap_q[2:0]}];
      mac_b = COS_ROM[{tap_q[2:0], cnt_q[2:0]}];
    end else if (state_q == COL) begin
      mac_a = tmp_ram[{tap_q[2:0], cnt_q[2:0]}];
      mac_b = COS_ROM[{tap_q[2:0], cnt_q[5:3]}];
    end
  end

  idct_mac u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (mac_clear),
    .en_i     (mac_en),
    .a_i      (mac_a),
    .b_i      (mac_b),
    .result_o (mac_res)
  );

  always_comb begin
    if (!mac_res[ACC_W-1] && (|mac_res[ACC_W-2:COEF_W-1])) begin
      row_sat = SAT_MAX;
    end else if (mac_res[ACC_W-1] && !(&mac_res[ACC_W-2:COEF_W-1])) begin
      row_sat = SAT_MIN;
    end else begin
      row_sat = mac_res[COEF_W-1:0];
    end
  end

  always_comb begin
    if (mac_res[ACC_W-1]) begin
      col_clip = '0;
    end else if (|mac_res[ACC_W-2:PIX_W]) begin
      col_clip = '1;
    end else begin
      col_clip = mac_res[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == LOAD) && coef_valid) begin
      coef_ram[cnt_q] <= data_in;
    end
    if ((state_q == ROW) && (tap_q == 4'd8)) begin
      tmp_ram[cnt_q] <= res_q;
    end
  end

  // Results are captured on tap 7, so pixel strobes land on tap 8 of each element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tap_q     <= '0;
      res_q     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      finish    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      finish    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            tap_q   <= '0;
          end
        end
        LOAD: begin
          if (coef_valid) begin
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
              state_q <= ROW;
              tap_q   <= '0;
            end
          end
        end
        ROW, COL: begin
          if (tap_q == 4'd7) begin
            if (state_q == ROW) begin
              res_q <= row_sat;
            end else begin
              data_out  <= col_clip;
              out_valid <= 1'b1;
            end
          end
          if (tap_q == 4'd8) begin
            tap_q <= '0;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
              if (state_q == ROW) begin
                state_q <= COL;
              end else begin
                state_q <= DONE;
                finish  <= 1'b1;
              end
            end
          end else begin
            tap_q <= tap_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
